// File: rtl/scan_vector_loader.sv
// Scan-style stimulus/response loader for combinational test cones.
// Latency: scan bits cycles 1..WIDTH after accept, capture at WIDTH+1, result from WIDTH+2.
// Backpressure: vec_ready only in IDLE; result held in RESULT until res_ready.
module scan_vector_loader #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  output logic             scan_out,
  output logic             scan_en,
  output logic [WIDTH-1:0] dut_in,
  output logic             capture,
  input  logic             resp_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic [CNT_W-1:0] res_count
);

  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESULT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dut_shift;
  logic [BW-1:0]    bitcnt;
  logic             last_bit;

  assign last_bit = (bitcnt == BW'(WIDTH - 1));

  // The bit leaving the scan chain enters dut_in from the top, so vec[0] lands in dut_in[0].
  generate
    if (WIDTH == 1) begin : g_w1
      assign dut_shift = shreg[0];
    end else begin : g_wn
      assign dut_shift = {shreg[0], dut_in[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_ready = 1'b0;
    scan_en   = 1'b0;
    scan_out  = 1'b0;
    capture   = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        vec_ready = 1'b1;
        if (vec_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        scan_en  = 1'b1;
        scan_out = shreg[0];
        if (last_bit) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      dut_in    <= '0;
      bitcnt    <= '0;
      res_data  <= 1'b0;
      res_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vec_valid) begin
            shreg  <= vec;
            bitcnt <= '0;
            dut_in <= '0;
          end
        end
        SHIFT: begin
          shreg  <= shreg >> 1;
          dut_in <= dut_shift;
          bitcnt <= bitcnt + 1'b1;
        end
        CAPTURE: begin
          res_data  <= resp_in;
          res_count <= res_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
